// File: rtl/exn_ctrl_nested.sv
// br32 exception/interrupt controller with a nested save-frame stack.
// Arbitrates rst/scall/udf/eret/irq and serves the control system registers.
module exn_ctrl_nested #(
  parameter int          NUM_IRQ     = 8,
  parameter int          STACK_DEPTH = 4,
  parameter logic [15:0] EDGE_MASK   = 16'h0,
  parameter logic [31:0] SR_BASE     = 32'h1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ex_bubble,
  input  logic               mem_scall,
  input  logic               mem_udf,
  input  logic               mem_eret,
  input  logic               mem_mtsr,
  input  logic [31:0]        mem_alu_res,
  input  logic [31:0]        mem_op3,
  input  logic [31:0]        mem_nextpc,
  input  logic               mem_w_cr,
  input  logic [1:0]         mem_cmp_res,
  input  logic [1:0]         cmp_reg,
  output logic               exn,
  output logic [5:0]         exn_type,
  output logic               eret,
  output logic [31:0]        sr_rdata,
  output logic [31:0]        elr,
  output logic [1:0]         scr,
  output logic [3:0]         irq_id
);

  localparam int TW = $clog2(STACK_DEPTH);
  localparam int DW = TW + 1;

  localparam logic [5:0] T_RST   = 6'd0;
  localparam logic [5:0] T_IRQ   = 6'd1;
  localparam logic [5:0] T_SCALL = 6'd2;
  localparam logic [5:0] T_UDF   = 6'd3;

  logic               ie;
  logic               ovf;
  logic [DW-1:0]      depth;
  logic [NUM_IRQ-1:0] imask;
  logic [NUM_IRQ-1:0] ipend;
  logic [NUM_IRQ-1:0] irq_prev;

  logic        f_ie   [STACK_DEPTH];
  logic [1:0]  f_cr   [STACK_DEPTH];
  logic [31:0] f_pc   [STACK_DEPTH];
  logic [31:0] f_info [STACK_DEPTH];

  logic [NUM_IRQ-1:0] edge_m;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] act;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] ipend_nx;
  logic [3:0]         irq_sel;

  logic [31:0]   sr_off_w;
  logic [2:0]    sr_off;
  logic          sr_hit;
  logic          sr_we;
  logic          true_ie;
  logic          take_irq;
  logic          has_top;
  logic          full;
  logic [TW-1:0] top;
  logic [TW-1:0] push_idx;
  logic          push;
  logic [31:0]   info;
  logic [1:0]    cr_now;

  logic ev_scall;
  logic ev_udf;
  logic ev_eret;
  logic ev_irq;

  assign edge_m = EDGE_MASK[NUM_IRQ-1:0];
  assign rise   = irq & ~irq_prev & edge_m;
  assign pend   = (irq & ~edge_m) | ipend;
  assign act    = pend & imask;

  always_comb begin
    irq_sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (act[i]) irq_sel = 4'(i);
  end

  assign irq_id = irq_sel;

  assign sr_off_w = mem_alu_res - SR_BASE;
  assign sr_off   = sr_off_w[2:0];
  assign sr_hit   = (sr_off_w[31:3] == '0);

  // An mtsr to IE in MEM decides interrupt acceptance this very cycle
  assign true_ie  = (mem_mtsr && sr_hit && sr_off == 3'd0)
                  ? mem_op3[0] : ie;
  assign take_irq = true_ie && (|act) && !ex_bubble;

  assign ev_scall = !rst && mem_scall;
  assign ev_udf   = !rst && !mem_scall && mem_udf;
  assign ev_eret  = !rst && !mem_scall && !mem_udf && mem_eret;
  assign ev_irq   = !rst && !mem_scall && !mem_udf && !mem_eret
                  && take_irq;

  always_comb begin
    exn      = 1'b0;
    exn_type = T_RST;
    eret     = 1'b0;
    unique case (1'b1)
      rst: exn = 1'b1;
      ev_scall: begin
        exn      = 1'b1;
        exn_type = T_SCALL;
      end
      ev_udf: begin
        exn      = 1'b1;
        exn_type = T_UDF;
      end
      ev_eret: begin
        exn  = 1'b1;
        eret = 1'b1;
      end
      ev_irq: begin
        exn      = 1'b1;
        exn_type = T_IRQ;
      end
      default: ;
    endcase
  end

  assign push     = ev_scall || ev_udf || ev_irq;
  assign sr_we    = mem_mtsr && !exn;
  assign has_top  = (depth != '0);
  assign full     = (depth == DW'(STACK_DEPTH));
  assign top      = depth[TW-1:0] - 1'b1;
  assign push_idx = full ? TW'(STACK_DEPTH - 1) : depth[TW-1:0];
  assign info     = ev_irq ? {28'b0, irq_sel} : mem_alu_res;
  assign cr_now   = mem_w_cr ? mem_cmp_res : cmp_reg;

  // A new edge in the same cycle always beats any clear of its latch
  always_comb begin
    clr = '0;
    if (ev_irq)
      clr = act & (~act + 1'b1) & edge_m;
    if (sr_we && sr_hit && sr_off == 3'd6)
      clr = clr | mem_op3[NUM_IRQ-1:0];
    ipend_nx = (ipend & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    irq_prev <= irq;
    if (rst) begin
      ie    <= 1'b0;
      ovf   <= 1'b0;
      depth <= '0;
      imask <= '0;
      ipend <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        f_ie[i]   <= 1'b0;
        f_cr[i]   <= '0;
        f_pc[i]   <= '0;
        f_info[i] <= '0;
      end
    end else begin
      ipend <= ipend_nx;
      if (push) begin
        f_ie[push_idx]   <= ie;
        f_cr[push_idx]   <= cr_now;
        f_pc[push_idx]   <= mem_nextpc;
        f_info[push_idx] <= info;
        ie               <= 1'b0;
        if (full) ovf   <= 1'b1;
        else      depth <= depth + 1'b1;
      end else if (ev_eret) begin
        if (has_top) begin
          ie    <= f_ie[top];
          depth <= depth - 1'b1;
        end
      end else if (sr_we && sr_hit) begin
        unique case (sr_off)
          3'd0: ie <= mem_op3[0];
          3'd1: if (has_top) f_ie[top] <= mem_op3[0];
          3'd2: if (has_top) f_cr[top] <= mem_op3[1:0];
          3'd3: if (has_top) f_pc[top] <= mem_op3;
          3'd4: if (has_top) f_info[top] <= mem_op3;
          3'd5: imask <= mem_op3[NUM_IRQ-1:0];
          3'd7: if (mem_op3[31]) ovf <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sr_rdata = '0;
    if (sr_hit) begin
      unique case (sr_off)
        3'd0: sr_rdata[0] = ie;
        3'd1: if (has_top) sr_rdata[0] = f_ie[top];
        3'd2: if (has_top) sr_rdata[1:0] = f_cr[top];
        3'd3: if (has_top) sr_rdata = f_pc[top];
        3'd4: if (has_top) sr_rdata = f_info[top];
        3'd5: sr_rdata[NUM_IRQ-1:0] = imask;
        3'd6: sr_rdata[NUM_IRQ-1:0] = ipend;
        3'd7: sr_rdata[DW:0] = {ovf, depth};
        default: ;
      endcase
    end
  end

  assign elr = has_top ? f_pc[top] : '0;
  assign scr = has_top ? f_cr[top] : '0;

endmodule
